// File: rtl/vmicro16_apb_rr_arbiter_pkg.sv
// Shared definitions for the vmicro16 APB round-robin arbiter.
// Holds the arbiter state encoding and the data word returned on forced completion.
package vmicro16_apb_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_SETUP  = 2'd1,
      ARB_ACCESS = 2'd2
   } arb_state_t;

   localparam logic [15:0] ARB_ERR_DATA = 16'hDEAD;

endpackage

// File: rtl/vmicro16_rr_picker.sv
// Combinational rotating priority encoder.
// Returns the first set request found after 'last', wrapping modulo MASTERS.
module vmicro16_rr_picker #(
   parameter int MASTERS = 4,
   parameter int GW      = $clog2(MASTERS)
) (
   input  logic [MASTERS-1:0] req,
   input  logic [GW-1:0]      last,
   output logic [GW-1:0]      next,
   output logic               any
);

   int idx;

   // Scan from the farthest offset down so the nearest requester after 'last' wins.
   always_comb begin
      next = '0;
      any  = 1'b0;
      idx  = 0;
      for (int k = MASTERS; k >= 1; k--) begin
         idx = (int'(last) + k) % MASTERS;
         if (req[idx[GW-1:0]]) begin
            next = idx[GW-1:0];
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vmicro16_apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port among MASTERS core-side requesters.
// Optional ACCESS-phase watchdog is built in when VMICRO16_ARB_TIMEOUT_EN is defined.
module vmicro16_apb_rr_arbiter
   import vmicro16_apb_rr_arbiter_pkg::*;
#(
   parameter int MASTERS    = 4,
   parameter int BUS_WIDTH  = 16,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [MASTERS*BUS_WIDTH-1:0]  S_PADDR,
   input  logic [MASTERS-1:0]            S_PWRITE,
   input  logic [MASTERS-1:0]            S_PSELx,
   input  logic [MASTERS-1:0]            S_PENABLE,
   input  logic [MASTERS*DATA_WIDTH-1:0] S_PWDATA,
   output logic [MASTERS*DATA_WIDTH-1:0] S_PRDATA,
   output logic [MASTERS-1:0]            S_PREADY,
   output logic [BUS_WIDTH-1:0]          M_PADDR,
   output logic                          M_PWRITE,
   output logic                          M_PSELx,
   output logic                          M_PENABLE,
   output logic [DATA_WIDTH-1:0]         M_PWDATA,
   input  logic [DATA_WIDTH-1:0]         M_PRDATA,
   input  logic                          M_PREADY,
`ifdef VMICRO16_ARB_TIMEOUT_EN
   output logic                          timeout_o,
`endif
   output logic [$clog2(MASTERS)-1:0]    grant,
   output logic                          busy
);

   localparam int GW = $clog2(MASTERS);

   arb_state_t    state;
   logic [GW-1:0] next_grant;
   logic          any_req;
   logic          timeout_hit;
   logic          done;
   logic          unused_ok;

   vmicro16_rr_picker #(
      .MASTERS (MASTERS),
      .GW      (GW)
   ) u_picker (
      .req  (S_PSELx),
      .last (grant),
      .next (next_grant),
      .any  (any_req)
   );

`ifdef VMICRO16_ARB_TIMEOUT_EN
   logic [7:0] cnt;

   assign timeout_hit = (state == ARB_ACCESS) && (cnt == 8'(TIMEOUT));
   assign unused_ok   = ^S_PENABLE;

   // Watchdog counts stalled ACCESS cycles; timeout_o is sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         timeout_o <= 1'b0;
      end else begin
         if (state == ARB_SETUP)
            cnt <= '0;
         else if (state == ARB_ACCESS && !M_PREADY && !timeout_hit)
            cnt <= cnt + 8'd1;
         if (timeout_hit)
            timeout_o <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign unused_ok   = ^{S_PENABLE, TIMEOUT[0]};
`endif

   assign done      = (state == ARB_ACCESS) && (M_PREADY || timeout_hit);
   assign busy      = (state != ARB_IDLE);
   assign M_PSELx   = (state != ARB_IDLE) && !timeout_hit;
   assign M_PENABLE = (state == ARB_ACCESS) && !timeout_hit;

   // Shared bus carries the granted slice; completion is routed back only to that slice.
   always_comb begin
      M_PADDR  = '0;
      M_PWRITE = 1'b0;
      M_PWDATA = '0;
      S_PREADY = '0;
      S_PRDATA = '0;
      for (int i = 0; i < MASTERS; i++) begin
         if (grant == GW'(i)) begin
            M_PADDR  = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
            M_PWRITE = S_PWRITE[i];
            M_PWDATA = S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
            if (done) begin
               S_PREADY[i] = 1'b1;
               S_PRDATA[i*DATA_WIDTH +: DATA_WIDTH] =
                  timeout_hit ? DATA_WIDTH'(ARB_ERR_DATA) : M_PRDATA;
            end
         end
      end
   end

   // Grant only advances from IDLE, so each transfer gets a turnaround cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ARB_IDLE;
         grant <= GW'(MASTERS - 1);
      end else begin
         case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  grant <= next_grant;
                  state <= ARB_SETUP;
               end
            end
            ARB_SETUP:  state <= ARB_ACCESS;
            ARB_ACCESS: if (done) state <= ARB_IDLE;
            default:    state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vmicro16_apb_rr_arbiter.sv
// Self-checking bench for vmicro16_apb_rr_arbiter with a behavioural round-robin model.
// Watchdog scenario is compiled in when VMICRO16_ARB_TIMEOUT_EN is defined.
module tb_vmicro16_apb_rr_arbiter;

   localparam int MASTERS = 4;
   localparam int BW      = 16;
   localparam int DW      = 16;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [MASTERS*BW-1:0] S_PADDR;
   logic [MASTERS-1:0]    S_PWRITE;
   logic [MASTERS-1:0]    S_PSELx;
   logic [MASTERS-1:0]    S_PENABLE;
   logic [MASTERS*DW-1:0] S_PWDATA;
   logic [MASTERS*DW-1:0] S_PRDATA;
   logic [MASTERS-1:0]    S_PREADY;
   logic [BW-1:0]         M_PADDR;
   logic                  M_PWRITE;
   logic                  M_PSELx;
   logic                  M_PENABLE;
   logic [DW-1:0]         M_PWDATA;
   logic [DW-1:0]         M_PRDATA;
   logic                  M_PREADY;
   logic [1:0]            grant;
   logic                  busy;
`ifdef VMICRO16_ARB_TIMEOUT_EN
   logic                  timeout_o;
`endif

   int errors = 0;
   int checks = 0;
   int waits_cfg = 0;
   logic [DW-1:0] rdata_cfg = '0;
   int stall = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   vmicro16_apb_rr_arbiter #(
      .MASTERS    (MASTERS),
      .BUS_WIDTH  (BW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .S_PADDR   (S_PADDR),
      .S_PWRITE  (S_PWRITE),
      .S_PSELx   (S_PSELx),
      .S_PENABLE (S_PENABLE),
      .S_PWDATA  (S_PWDATA),
      .S_PRDATA  (S_PRDATA),
      .S_PREADY  (S_PREADY),
      .M_PADDR   (M_PADDR),
      .M_PWRITE  (M_PWRITE),
      .M_PSELx   (M_PSELx),
      .M_PENABLE (M_PENABLE),
      .M_PWDATA  (M_PWDATA),
      .M_PRDATA  (M_PRDATA),
      .M_PREADY  (M_PREADY),
`ifdef VMICRO16_ARB_TIMEOUT_EN
      .timeout_o (timeout_o),
`endif
      .grant     (grant),
      .busy      (busy)
   );

   // Round-robin rule: first requester after the last winner, wrapping around.
   function automatic int model_pick(input logic [MASTERS-1:0] req, input int last);
      for (int k = 1; k <= MASTERS; k++) begin
         int j;
         j = (last + k) % MASTERS;
         if (req[j[1:0]]) return j;
      end
      return -1;
   endfunction

   // One clock of a slave that inserts waits_cfg wait states per ACCESS phase.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (M_PSELx && M_PENABLE) begin
         M_PREADY = (stall >= waits_cfg);
         M_PRDATA = M_PREADY ? rdata_cfg : '0;
         stall++;
      end else begin
         M_PREADY = 1'b0;
         M_PRDATA = '0;
         stall    = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      S_PSELx   = '0;
      S_PENABLE = '0;
      S_PWRITE  = '0;
      S_PADDR   = '0;
      S_PWDATA  = '0;
      M_PREADY  = 1'b0;
      M_PRDATA  = '0;
      stall     = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (M_PSELx !== 1'b0) begin errors++; $display("[TB] FAIL reset_psel: got %b expected 0", M_PSELx); end
      checks++; if (M_PENABLE !== 1'b0) begin errors++; $display("[TB] FAIL reset_penable: got %b expected 0", M_PENABLE); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (S_PREADY !== '0) begin errors++; $display("[TB] FAIL reset_pready: got %b expected 0", S_PREADY); end
      checks++; if (S_PRDATA !== '0) begin errors++; $display("[TB] FAIL reset_prdata: got %h expected 0", S_PRDATA); end
      checks++; if (grant !== 2'd3) begin errors++; $display("[TB] FAIL reset_grant: got %0d expected 3", grant); end
   endtask

   task automatic test_single_read();
      int psel_cnt = 0;
      int rdy_cnt  = 0;
      do_reset();
      waits_cfg = 2;
      rdata_cfg = 16'h1234;
      S_PADDR[1*BW +: BW] = 16'h0010;
      S_PSELx = 4'b0010;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (M_PSELx) psel_cnt++;
         if (S_PREADY != '0) begin
            rdy_cnt++;
            checks++; if (S_PREADY !== 4'b0010) begin errors++; $display("[TB] FAIL read_pready: got %b expected 0010", S_PREADY); end
            checks++; if (S_PRDATA !== {16'h0, 16'h0, 16'h1234, 16'h0}) begin errors++; $display("[TB] FAIL read_prdata: got %h expected %h", S_PRDATA, {16'h0, 16'h0, 16'h1234, 16'h0}); end
            checks++; if (M_PADDR !== 16'h0010) begin errors++; $display("[TB] FAIL read_paddr: got %h expected 0010", M_PADDR); end
            S_PSELx = '0;
         end
      end
      checks++; if (psel_cnt != 4) begin errors++; $display("[TB] FAIL read_psel_cycles: got %0d expected 4", psel_cnt); end
      checks++; if (rdy_cnt != 1) begin errors++; $display("[TB] FAIL read_pready_pulses: got %0d expected 1", rdy_cnt); end
   endtask

   task automatic test_simultaneous();
      int got[$];
      int expq[2] = '{0, 2};
      do_reset();
      waits_cfg = 0;
      S_PSELx = 4'b0101;
      for (int c = 0; c < 30 && got.size() < 2; c++) begin
         tick();
         if (S_PREADY != '0) begin
            got.push_back(int'(grant));
            S_PSELx[grant] = 1'b0;
         end
      end
      checks++; if (got.size() != 2) begin errors++; $display("[TB] FAIL simul_count: got %0d expected 2", got.size()); end
      for (int i = 0; i < got.size() && i < 2; i++) begin
         checks++; if (got[i] != expq[i]) begin errors++; $display("[TB] FAIL simul_order%0d: got %0d expected %0d", i, got[i], expq[i]); end
      end
   endtask

   task automatic test_fairness();
      int g[$];
      int t[$];
      do_reset();
      waits_cfg = 0;
      S_PSELx = 4'b1111;
      for (int c = 0; c < 40 && g.size() < 6; c++) begin
         tick();
         if (S_PREADY != '0) begin
            g.push_back(int'(grant));
            t.push_back(cyc);
            if (g.size() == 6) S_PSELx = '0;
         end
      end
      checks++; if (g.size() != 6) begin errors++; $display("[TB] FAIL fair_count: got %0d expected 6", g.size()); end
      for (int i = 0; i < g.size(); i++) begin
         checks++; if (g[i] != i % MASTERS) begin errors++; $display("[TB] FAIL fair_grant%0d: got %0d expected %0d", i, g[i], i % MASTERS); end
         if (i > 0) begin
            checks++; if (t[i] - t[i-1] != 3) begin errors++; $display("[TB] FAIL fair_spacing%0d: got %0d expected 3", i, t[i] - t[i-1]); end
         end
      end
   endtask

   task automatic test_write();
      int phases = 0;
      do_reset();
      waits_cfg = 1;
      for (int i = 0; i < MASTERS; i++) begin
         S_PADDR[i*BW +: BW]  = 16'($urandom);
         S_PWDATA[i*DW +: DW] = 16'($urandom);
      end
      S_PADDR[3*BW +: BW]  = 16'h0204;
      S_PWDATA[3*DW +: DW] = 16'hBEEF;
      S_PWRITE = 4'b1000;
      S_PSELx  = 4'b1000;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (M_PSELx) begin
            phases++;
            checks++; if (M_PADDR !== 16'h0204) begin errors++; $display("[TB] FAIL write_paddr: got %h expected 0204", M_PADDR); end
            checks++; if (M_PWDATA !== 16'hBEEF) begin errors++; $display("[TB] FAIL write_pwdata: got %h expected beef", M_PWDATA); end
            checks++; if (M_PWRITE !== 1'b1) begin errors++; $display("[TB] FAIL write_pwrite: got %b expected 1", M_PWRITE); end
            checks++; if (grant !== 2'd3) begin errors++; $display("[TB] FAIL write_grant: got %0d expected 3", grant); end
         end
         if (S_PREADY != '0) S_PSELx = '0;
      end
      checks++; if (phases != 3) begin errors++; $display("[TB] FAIL write_phases: got %0d expected 3", phases); end
      S_PWRITE = '0;
   endtask

   task automatic test_reset_mid_access();
      bit reached = 0;
      bit served  = 0;
      do_reset();
      waits_cfg = 1000;
      S_PSELx = 4'b0100;
      for (int c = 0; c < 10 && !reached; c++) begin
         tick();
         if (M_PENABLE) reached = 1;
      end
      checks++; if (!reached) begin errors++; $display("[TB] FAIL rstmid_access: got 0 expected 1"); end
      reset = 1'b1;
      #1;
      checks++; if (M_PSELx !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_psel: got %b expected 0", M_PSELx); end
      checks++; if (S_PREADY !== '0) begin errors++; $display("[TB] FAIL rstmid_pready: got %b expected 0", S_PREADY); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
      @(posedge clk);
      #1;
      reset     = 1'b0;
      M_PREADY  = 1'b0;
      stall     = 0;
      waits_cfg = 0;
      S_PSELx   = 4'b1111;
      for (int c = 0; c < 10 && !served; c++) begin
         tick();
         if (S_PREADY != '0) begin
            served = 1;
            checks++; if (grant !== 2'd0) begin errors++; $display("[TB] FAIL rstmid_next_grant: got %0d expected 0", grant); end
            S_PSELx = '0;
         end
      end
      checks++; if (!served) begin errors++; $display("[TB] FAIL rstmid_served: got 0 expected 1"); end
   endtask

   task automatic test_random();
      int last = MASTERS - 1;
      do_reset();
      for (int n = 0; n < 30; n++) begin
         logic [MASTERS-1:0]    req;
         logic [MASTERS*DW-1:0] exp_data;
         logic [MASTERS-1:0]    exp_rdy;
         int exp_g;
         bit done = 0;
         req = 4'($urandom_range(1, 15));
         for (int i = 0; i < MASTERS; i++) begin
            S_PADDR[i*BW +: BW]  = 16'($urandom);
            S_PWDATA[i*DW +: DW] = 16'($urandom);
         end
         waits_cfg = $urandom_range(0, 3);
         rdata_cfg = 16'($urandom);
         S_PSELx   = req;
         exp_g     = model_pick(req, last);
         exp_data  = '0;
         exp_data[exp_g*DW +: DW] = rdata_cfg;
         exp_rdy   = 4'(1 << exp_g);
         for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (S_PREADY != '0) begin
               done = 1;
               checks++; if (int'(grant) != exp_g) begin errors++; $display("[TB] FAIL rand_grant%0d: got %0d expected %0d", n, grant, exp_g); end
               checks++; if (S_PREADY !== exp_rdy) begin errors++; $display("[TB] FAIL rand_pready%0d: got %b expected %b", n, S_PREADY, exp_rdy); end
               checks++; if (S_PRDATA !== exp_data) begin errors++; $display("[TB] FAIL rand_prdata%0d: got %h expected %h", n, S_PRDATA, exp_data); end
               checks++; if (M_PADDR !== S_PADDR[exp_g*BW +: BW]) begin errors++; $display("[TB] FAIL rand_paddr%0d: got %h expected %h", n, M_PADDR, S_PADDR[exp_g*BW +: BW]); end
            end
         end
         checks++; if (!done) begin errors++; $display("[TB] FAIL rand_complete%0d: got 0 expected 1", n); end
         last    = exp_g;
         S_PSELx = '0;
      end
   endtask

`ifdef VMICRO16_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int  pen_cnt = 0;
      bit  seen    = 0;
      do_reset();
      waits_cfg = 1000;
      S_PSELx = 4'b0010;
      for (int c = 0; c < 30 && !seen; c++) begin
         tick();
         if (M_PENABLE) pen_cnt++;
         if (S_PREADY != '0) begin
            seen = 1;
            checks++; if (S_PREADY !== 4'b0010) begin errors++; $display("[TB] FAIL tmo_pready: got %b expected 0010", S_PREADY); end
            checks++; if (S_PRDATA !== {16'h0, 16'h0, 16'hDEAD, 16'h0}) begin errors++; $display("[TB] FAIL tmo_prdata: got %h expected dead in slice 1", S_PRDATA); end
            checks++; if (M_PSELx !== 1'b0) begin errors++; $display("[TB] FAIL tmo_psel: got %b expected 0", M_PSELx); end
            checks++; if (pen_cnt != 4) begin errors++; $display("[TB] FAIL tmo_stalls: got %0d expected 4", pen_cnt); end
            S_PSELx = '0;
         end
      end
      checks++; if (!seen) begin errors++; $display("[TB] FAIL tmo_seen: got 0 expected 1"); end
      tick();
      checks++; if (timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL tmo_flag: got %b expected 1", timeout_o); end
   endtask
`endif

   initial begin
      reset = 1'b1;
      test_reset();
      test_single_read();
      test_simultaneous();
      test_fairness();
      test_write();
      test_reset_mid_access();
      test_random();
`ifdef VMICRO16_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
